// File: rtl/pip_pkg.sv
// Shared constants, arbitration select type and mask helper for the pipeline hazard controller.
package pip_pkg;

  localparam int unsigned STALL_BUS   = 6;
  localparam int unsigned STG_IF      = 0;
  localparam int unsigned STG_ID      = 2;
  localparam int unsigned STG_EX      = 3;
  localparam int unsigned STG_MEM     = 4;
  localparam int unsigned STG_WB      = 5;
  localparam int unsigned DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ArbNone,
    ArbGlobal,
    ArbPending,
    ArbExcept,
    ArbStage
  } arb_sel_e;

  // Thermometer mask with bits [idx:0] set; callers slice to their stage count.
  function automatic logic [31:0] therm_mask(input logic [31:0] idx);
    logic [31:0] m;
    m = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      if (j <= idx) m[j] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pip_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturating at TIMEOUT, and flags expiry.
module pip_watchdog
  import pip_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic stall_active,
  output logic stall_timeout
);

  localparam logic [CW-1:0] Limit = CW'(TIMEOUT);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q;

  always_comb begin
    wd_cnt_d = '0;
    if (stall_active) begin
      wd_cnt_d = (wd_cnt_q == Limit) ? wd_cnt_q : wd_cnt_q + CW'(1);
    end
  end

  // Flag is registered alongside the counter so it rises and clears on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= (wd_cnt_d == Limit);
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: rtl/pip_ctrl_gen.sv
// Pipeline stall/flush/bubble arbiter with deferred exceptions and a stall watchdog.
// Optional performance counters enabled by defining PIP_PERF_CNT_EN.
module pip_ctrl_gen
  import pip_pkg::*;
#(
  parameter int unsigned STAGES  = STALL_BUS,
  parameter int unsigned SW      = $clog2(STAGES),
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STAGES-1:0] stallreq_stage,
  input  logic              stallreq_global,
  input  logic              except_en,
  input  logic [SW-1:0]     except_stage,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] bubble,
  output logic              flush_pending,
  output logic              stall_timeout,
  output logic [31:0]       stall_cycle_cnt,
  output logic [31:0]       flush_cnt
);

  localparam logic [SW-1:0] LastStg = SW'(STAGES - 1);

  logic          pend_vld_q, pend_vld_d;
  logic [SW-1:0] pend_stage_q, pend_stage_d;
  logic [SW-1:0] exc_stg, top_req;
  logic [31:0]   pend_mask, exc_mask, req_mask, req_mask_up, bub_mask;
  arb_sel_e      sel;

  assign exc_stg = (except_stage > LastStg) ? LastStg : except_stage;

  always_comb begin
    top_req = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (stallreq_stage[i]) top_req = SW'(i);
    end
  end

  assign pend_mask   = therm_mask(32'(pend_stage_q));
  assign exc_mask    = therm_mask(32'(exc_stg));
  assign req_mask    = therm_mask(32'(top_req));
  assign req_mask_up = therm_mask(32'(top_req) + 32'd1);
  // Single bit just above the oldest stalled stage; falls off the top when k is writeback.
  assign bub_mask    = req_mask_up ^ req_mask;

  always_comb begin
    if (reset)                 sel = ArbNone;
    else if (stallreq_global)  sel = ArbGlobal;
    else if (pend_vld_q)       sel = ArbPending;
    else if (except_en)        sel = ArbExcept;
    else if (|stallreq_stage)  sel = ArbStage;
    else                       sel = ArbNone;
  end

  always_comb begin
    stall  = '0;
    flush  = '0;
    bubble = '0;
    unique case (sel)
      ArbGlobal:  stall = '1;
      ArbPending: flush = pend_mask[STAGES-1:0];
      ArbExcept:  flush = exc_mask[STAGES-1:0];
      ArbStage: begin
        stall  = req_mask[STAGES-1:0];
        bubble = bub_mask[STAGES-1:0];
      end
      default: ;
    endcase
  end

  // An exception seen under global stall is held; the older stage wins on collision.
  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_stage_d = pend_stage_q;
    if (stallreq_global) begin
      if (except_en && (!pend_vld_q || exc_stg >= pend_stage_q)) begin
        pend_vld_d   = 1'b1;
        pend_stage_d = exc_stg;
      end
    end else if (pend_vld_q) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld_q   <= 1'b0;
      pend_stage_q <= '0;
    end else begin
      pend_vld_q   <= pend_vld_d;
      pend_stage_q <= pend_stage_d;
    end
  end

  assign flush_pending = pend_vld_q;

  pip_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .stall_active (|stall),
    .stall_timeout(stall_timeout)
  );

`ifdef PIP_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (|stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (|flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycle_cnt = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;
`else
  assign stall_cycle_cnt = '0;
  assign flush_cnt       = '0;
`endif

endmodule

// File: tb/tb_pip_ctrl_gen.sv
// Self-checking bench for pip_ctrl_gen: directed scenarios plus random traffic vs a reference model.
module tb_pip_ctrl_gen;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic [5:0]  stallreq_stage;
  logic        stallreq_global;
  logic        except_en;
  logic [2:0]  except_stage;
  logic [5:0]  stall, flush, bubble;
  logic        flush_pending, stall_timeout;
  logic [31:0] stall_cycle_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_pend;
  int          m_pstage;
  int          m_wd;
  bit          m_to;
  logic [31:0] m_scnt, m_fcnt;

  pip_ctrl_gen #(
    .STAGES (6),
    .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stallreq_stage (stallreq_stage),
    .stallreq_global(stallreq_global),
    .except_en      (except_en),
    .except_stage   (except_stage),
    .stall          (stall),
    .flush          (flush),
    .bubble         (bubble),
    .flush_pending  (flush_pending),
    .stall_timeout  (stall_timeout),
    .stall_cycle_cnt(stall_cycle_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] low_ones(input int n);
    int v;
    v = (1 << (n + 1)) - 1;
    return 6'(v);
  endfunction

  task automatic model_clear();
    m_pend   = 1'b0;
    m_pstage = 0;
    m_wd     = 0;
    m_to     = 1'b0;
    m_scnt   = '0;
    m_fcnt   = '0;
  endtask

  // One cycle: drive at negedge, compare just after, then advance the model at posedge.
  task automatic step(input bit g, input bit [5:0] sr, input bit ee, input bit [2:0] es);
    int cl, k;
    logic [5:0] e_st, e_fl, e_bb;
    @(negedge clk);
    stallreq_global = g;
    stallreq_stage  = sr;
    except_en       = ee;
    except_stage    = es;
    #1;
    e_st = '0;
    e_fl = '0;
    e_bb = '0;
    cl   = (int'(es) > 5) ? 5 : int'(es);
    if (g) begin
      e_st = 6'b111111;
    end else if (m_pend) begin
      e_fl = low_ones(m_pstage);
    end else if (ee) begin
      e_fl = low_ones(cl);
    end else if (sr != 0) begin
      k    = $clog2(int'(sr) + 1) - 1;
      e_st = low_ones(k);
      if (k < 5) e_bb = 6'(1 << (k + 1));
    end
    check("stall", 32'(stall), 32'(e_st));
    check("flush", 32'(flush), 32'(e_fl));
    check("bubble", 32'(bubble), 32'(e_bb));
    check("flush_pending", 32'(flush_pending), 32'(m_pend));
    check("stall_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef PIP_PERF_CNT_EN
    check("stall_cycle_cnt", stall_cycle_cnt, m_scnt);
    check("flush_cnt", flush_cnt, m_fcnt);
`else
    check("stall_cycle_cnt", stall_cycle_cnt, 32'd0);
    check("flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk);
    if (g) begin
      if (ee && (!m_pend || cl >= m_pstage)) begin
        m_pend   = 1'b1;
        m_pstage = cl;
      end
    end else begin
      m_pend = 1'b0;
    end
    m_wd = (e_st != 0) ? ((m_wd + 1 > TO) ? TO : m_wd + 1) : 0;
    m_to = (m_wd == TO);
    if (e_st != 0) m_scnt = m_scnt + 32'd1;
    if (e_fl != 0) m_fcnt = m_fcnt + 32'd1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_bubble"}, 32'(bubble), 32'd0);
    check({tag, "_pending"}, 32'(flush_pending), 32'd0);
    check({tag, "_timeout"}, 32'(stall_timeout), 32'd0);
  endtask

  initial begin
    bit       g, ee;
    bit [5:0] sr;
    bit [2:0] es;
    model_clear();
    reset           = 1'b1;
    stallreq_stage  = 6'b111111;
    stallreq_global = 1'b0;
    except_en       = 1'b1;
    except_stage    = 3'd2;
    #2;
    check_zero_outputs("reset_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Stage request: stall thermometer plus bubble above it
    step(0, 6'b000100, 0, 0);
    step(0, 6'b100000, 0, 0);
    step(0, 6'b001010, 0, 0);
    step(0, 6'b000000, 0, 0);

    // Exception deferred across a global stall
    step(1, 0, 1, 3);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Oldest pending exception wins during global stall
    step(1, 0, 1, 2);
    step(1, 0, 1, 4);
    step(1, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Exception beats stage stall; out-of-range stage clamps
    step(0, 6'b000100, 1, 5);
    step(0, 0, 1, 7);
    step(0, 0, 0, 0);

    // Watchdog rise, hold, clear
    for (int i = 0; i < 10; i++) step(0, 6'b000010, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset asserted while an exception is pending
    step(1, 0, 1, 4);
    @(negedge clk);
    stallreq_global = 1'b0;
    stallreq_stage  = 6'b000100;
    except_en       = 1'b0;
    reset           = 1'b1;
    #1;
    check_zero_outputs("reset_mid");
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic including occasional long stalls
    for (int n = 0; n < 1500; n++) begin
      g  = ($urandom_range(0, 9) == 0);
      ee = ($urandom_range(0, 5) == 0);
      es = 3'($urandom_range(0, 7));
      sr = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      if ($urandom_range(0, 99) == 0) begin
        for (int r = 0; r < 12; r++) step(0, sr | 6'b000001, 0, 0);
      end
      step(g, sr, ee, es);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pip_ctrl_gen.md
Name: pip_ctrl_gen

Overview:
- Parametrised pipeline hazard controller. Second-generation stall/flush arbiter for the in-order LoongArch core.
- Turns per-stage stall requests, a global memory/AXI stall and exception requests into thermometer stall masks, per-stage flush masks and bubble-insert strobes.
- Adds behaviour the six-stage fixed arbiter lacks:
  - exceptions arriving during a global stall are deferred, not dropped;
  - a watchdog flags stalls that last too long.
- Sits beside the datapath; every pipeline register consumes its stall, flush and bubble bit.

Parameters:
- STAGES, 6, number of pipeline stages. Index 0 = fetch (youngest), STAGES-1 = writeback (oldest).
- SW, $clog2(STAGES), width of a stage index.
- TIMEOUT, 1024, consecutive stalled cycles before stall_timeout asserts. Must be ≥2.
- CW, $clog2(TIMEOUT+1), watchdog counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- stallreq_stage  in  STAGES  bit i = stage i requests a stall
- stallreq_global  in  1  AXI/cache miss; freezes the whole pipeline
- except_en  in  1  exception/ertn redirect request, single-cycle
- except_stage  in  SW  stage raising except_en
- stall  out  STAGES  stall mask, bit i freezes stage i
- flush  out  STAGES  flush mask, bit i kills stage i contents
- bubble  out  STAGES  bit i = insert NOP into stage i
- flush_pending  out  1  an exception is latched and awaiting delivery
- stall_timeout  out  1  watchdog expired
- stall_cycle_cnt  out  32  performance counter (optional feature)
- flush_cnt  out  32  performance counter (optional feature)

Behaviour:
- Reset (asynchronous, active-high):
  - all registers clear: pend_vld, pend_stage, wd_cnt, stall_timeout, counters;
  - while reset is high, all combinational outputs are forced to 0.
- Registers: pend_vld, pend_stage[SW-1:0], wd_cnt[CW-1:0], stall_timeout, optional counters. stall, flush and bubble are combinational: 0-cycle latency from the inputs and pend_* state.
- Priority, highest first:
  1. stallreq_global → stall = all ones, flush = 0, bubble = 0. If except_en is also high, capture it: pend_vld=1, pend_stage=except_stage. Only overwrite an existing pending entry when except_stage ≥ pend_stage (the older instruction wins).
  2. pend_vld (and global low) → flush[j]=1 for j ≤ pend_stage, stall = 0. Clear pend_vld next edge. A simultaneous except_en is ignored; it belongs to a stage already being flushed.
  3. except_en → flush[j]=1 for j ≤ except_stage, stall = 0, bubble = 0.
  4. Any stallreq_stage bit set, k = highest set index → stall[j]=1 for j ≤ k. If k < STAGES-1, bubble[k+1]=1, else bubble = 0.
  5. Otherwise stall = flush = bubble = 0.
- except_stage ≥ STAGES is clamped to STAGES-1.
- flush_pending = pend_vld.
- Watchdog:
  - wd_cnt increments (saturating at TIMEOUT) each cycle any stall bit is 1;
  - it clears on any cycle with stall == 0;
  - stall_timeout = registered (wd_cnt == TIMEOUT); it clears with wd_cnt;
  - a flush cycle counts as unstalled.

Optional Feature:
- Macro: PIP_PERF_CNT_EN.
- Defined:
  - stall_cycle_cnt increments each cycle stall != 0;
  - flush_cnt increments each cycle flush != 0;
  - both are 32-bit, wrap modulo 2^32, reset to 0.
- Undefined: both ports are tied to 32'b0 and no counter flops are instantiated.

Decomposition:
- Shared package pip_pkg:
  - STALL_BUS default (6);
  - stage index constants STG_IF=0, STG_ID=2, STG_EX=3, STG_MEM=4, STG_WB=5;
  - TIMEOUT default.
- One sub-module, pip_watchdog (stall-active in, stall_timeout out, parameter TIMEOUT). Everything else stays flat.

Test Plan:
- stallreq_stage=6'b000100, nothing else → stall=000111, bubble=001000, flush=0, all 0 latency.
- stallreq_global=1 for 3 cycles with except_en=1, except_stage=3 in cycle 1 → stall=111111, flush=0 throughout, flush_pending=1. First cycle after global drops: flush=001111, stall=0. Next cycle flush_pending=0.
- During global stall: except_stage=2, then except_stage=4, then except_stage=1 → delivered flush=011111 (oldest wins).
- except_en=1, except_stage=5 together with stallreq_stage=000100 → flush=111111, stall=0, bubble=0.
- TIMEOUT=8, stallreq_stage[1] held 10 cycles → stall_timeout rises after 8 stalled cycles and is held. One unstalled cycle → counter and flag clear.
- Assert reset mid-pending (pend_vld=1) → outputs 0 immediately. After release, no flush is delivered and counters read 0.
